// File: rtl/tree_add_seq_if.sv
// Producer/consumer handshake bundle for tree_add_seq.
// The slave modport is the sequencer's view; master is the surrounding system.
interface tree_add_seq_if #(
    parameter int A_W = 4,
    parameter int C_W = 8
);
    // Operand side
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] a;
    logic [A_W-1:0] b;
    logic [C_W-1:0] c;
    logic [C_W-1:0] d;

    // Result side
    logic           out_valid;
    logic           out_ready;
    logic [A_W:0]   op1;
    logic [C_W:0]   op2;
    logic [C_W+1:0] sum;

    // Status
    logic           busy;
    logic [7:0]     done_cnt;

    modport slave (
        input  in_valid, a, b, c, d, out_ready,
        output in_ready, out_valid, op1, op2, sum, busy, done_cnt
    );

    modport master (
        output in_valid, a, b, c, d, out_ready,
        input  in_ready, out_valid, op1, op2, sum, busy, done_cnt
    );
endinterface

// File: rtl/tree_add_seq.sv
// Two-level adder tree (a+b, c+d, then their sum) evaluated over three cycles
// on a single shared C_W+2 bit adder, with valid/ready on both sides and a
// wrapping count of results handed to the consumer.
module tree_add_seq #(
    parameter int A_W = 4,   // must not exceed C_W
    parameter int C_W = 8
) (
    input  logic          clk,
    input  logic          rst,
    tree_add_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        S_OP1 = 3'd1,
        S_OP2 = 3'd2,
        S_SUM = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [A_W-1:0] a_q, a_d;
    logic [A_W-1:0] b_q, b_d;
    logic [C_W-1:0] c_q, c_d;
    logic [C_W-1:0] d_q, d_d;
    logic [A_W:0]   op1_q, op1_d;
    logic [C_W:0]   op2_q, op2_d;
    logic [C_W+1:0] sum_q, sum_d;
    logic [7:0]     done_cnt_q, done_cnt_d;

    // Shared adder operands and result; wide enough that no stage loses a carry.
    logic [C_W+1:0] add_x, add_y, add_r;

    logic accept;
    logic handoff;

    assign accept  = bus.in_valid && (state_q == IDLE);
    assign handoff = bus.out_ready && (state_q == DONE);

    // State register with synchronous reset to IDLE.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: one adder stage per cycle, wait in DONE for the consumer.
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves
        // state_d unassigned, which would infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)  state_d = S_OP1;
            S_OP1:   state_d = S_OP2;
            S_OP2:   state_d = S_SUM;
            S_SUM:   state_d = DONE;
            DONE:    if (handoff) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and status outputs decoded purely from the current state.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
    end

    // Adder operand mux: zero-extend whichever pair the current stage needs.
    always_comb begin
        add_x = '0;
        add_y = '0;
        unique case (state_q)
            S_OP1: begin
                add_x = {{(C_W+2-A_W){1'b0}}, a_q};
                add_y = {{(C_W+2-A_W){1'b0}}, b_q};
            end
            S_OP2: begin
                add_x = {2'b00, c_q};
                add_y = {2'b00, d_q};
            end
            S_SUM: begin
                add_x = {{(C_W+1-A_W){1'b0}}, op1_q};
                add_y = {1'b0, op2_q};
            end
            default: begin
                add_x = '0;
                add_y = '0;
            end
        endcase
    end

    // The single adder instance.
    assign add_r = add_x + add_y;

    // Datapath next values: capture operands on accept, one result per stage.
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        c_d        = c_q;
        d_d        = d_q;
        op1_d      = op1_q;
        op2_d      = op2_q;
        sum_d      = sum_q;
        done_cnt_d = done_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d = bus.a;
                    b_d = bus.b;
                    c_d = bus.c;
                    d_d = bus.d;
                end
            end
            S_OP1:   op1_d = add_r[A_W:0];
            S_OP2:   op2_d = add_r[C_W:0];
            S_SUM:   sum_d = add_r;
            DONE:    if (handoff) done_cnt_d = done_cnt_q + 8'd1;
            default: ;
        endcase
    end

    // Datapath registers; reset discards any in-flight operation uncounted.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            c_q        <= '0;
            d_q        <= '0;
            op1_q      <= '0;
            op2_q      <= '0;
            sum_q      <= '0;
            done_cnt_q <= '0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            c_q        <= c_d;
            d_q        <= d_d;
            op1_q      <= op1_d;
            op2_q      <= op2_d;
            sum_q      <= sum_d;
            done_cnt_q <= done_cnt_d;
        end
    end

    assign bus.op1      = op1_q;
    assign bus.op2      = op2_q;
    assign bus.sum      = sum_q;
    assign bus.done_cnt = done_cnt_q;

endmodule

// File: tb/tb_tree_add_seq.sv
// Directed bench for tree_add_seq: scoreboard of expected results filled on
// each accept and drained on each handoff, plus cycle-accurate spot checks.
module tb_tree_add_seq;

    localparam int A_W = 4;
    localparam int C_W = 8;

    logic clk;
    logic rst;

    tree_add_seq_if #(.A_W(A_W), .C_W(C_W)) bus ();

    tree_add_seq #(.A_W(A_W), .C_W(C_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        int op1;
        int op2;
        int sum;
    } exp_t;

    exp_t       sb[$];
    int         acc_cyc[$];
    int         n_checks  = 0;
    int         n_fail    = 0;
    int         cyc       = 0;
    int         acc_cnt   = 0;
    int         hand_cnt  = 0;
    logic [7:0] exp_done  = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Monitor at the falling edge: what the DUT will do at the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            exp_done = '0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                e.op1 = int'(bus.a) + int'(bus.b);
                e.op2 = int'(bus.c) + int'(bus.d);
                e.sum = e.op1 + e.op2;
                sb.push_back(e);
                acc_cyc.push_back(cyc);
                acc_cnt++;
            end
            if (bus.out_valid && bus.out_ready) begin
                check("sb_has_entry", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sb_op1", 32'(bus.op1), e.op1);
                    check("sb_op2", 32'(bus.op2), e.op2);
                    check("sb_sum", 32'(bus.sum), e.sum);
                end
                exp_done = exp_done + 8'd1;
                hand_cnt++;
            end
        end
    end

    // Advance to just after the next rising edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a, input int b, input int c, input int d);
        bus.a = A_W'(a);
        bus.b = B_W_cast(b);
        bus.c = C_W'(c);
        bus.d = C_W'(d);
    endtask

    function automatic logic [A_W-1:0] B_W_cast(input int v);
        return A_W'(v);
    endfunction

    task automatic wait_accept(input int target);
        int n = 0;
        while (acc_cnt < target && n < 50) begin
            next();
            n++;
        end
        check("accept_in_time", 32'(acc_cnt >= target), 1);
    endtask

    task automatic wait_hand(input int target);
        int n = 0;
        while (hand_cnt < target && n < 50) begin
            next();
            n++;
        end
        check("handoff_in_time", 32'(hand_cnt >= target), 1);
    endtask

    task automatic run_op(input int a, input int b, input int c, input int d);
        int h0;
        h0 = hand_cnt;
        drive(a, b, c, d);
        bus.in_valid = 1'b1;
        wait_accept(acc_cnt + 1);
        bus.in_valid = 1'b0;
        wait_hand(h0 + 1);
    endtask

    initial begin
        int a0;
        int h0;
        int n;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        drive(0, 0, 0, 0);
        repeat (3) next();
        rst = 1'b0;

        // Reset state, first cycle after deassertion.
        check("rst_in_ready",  32'(bus.in_ready),  1);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_busy",      32'(bus.busy),      0);
        check("rst_op1",       32'(bus.op1),       0);
        check("rst_op2",       32'(bus.op2),       0);
        check("rst_sum",       32'(bus.sum),       0);
        check("rst_done_cnt",  32'(bus.done_cnt),  0);

        // Basic result with cycle-by-cycle timing.
        bus.out_ready = 1'b1;
        drive(0, 3, 1, 255);
        bus.in_valid = 1'b1;
        wait_accept(1);
        bus.in_valid = 1'b0;
        check("t0_busy",      32'(bus.busy),      1);
        check("t0_in_ready",  32'(bus.in_ready),  0);
        check("t0_out_valid", 32'(bus.out_valid), 0);
        next();
        check("t1_op1",       32'(bus.op1),       3);
        check("t1_out_valid", 32'(bus.out_valid), 0);
        next();
        check("t2_op2",       32'(bus.op2),       256);
        check("t2_out_valid", 32'(bus.out_valid), 0);
        next();
        check("t3_out_valid", 32'(bus.out_valid), 1);
        check("t3_sum",       32'(bus.sum),       259);
        next();
        check("post_out_valid", 32'(bus.out_valid), 0);
        check("post_busy",      32'(bus.busy),      0);
        check("post_in_ready",  32'(bus.in_ready),  1);
        check("post_done_cnt",  32'(bus.done_cnt),  1);

        // Back-to-back stream with in_valid and out_ready held high.
        a0 = acc_cnt;
        h0 = hand_cnt;
        drive(10, 13, 9, 10);
        bus.in_valid = 1'b1;
        wait_accept(a0 + 1);
        drive(15, 15, 109, 37);
        wait_accept(a0 + 2);
        drive(0, 9, 45, 45);
        wait_accept(a0 + 3);
        bus.in_valid = 1'b0;
        wait_hand(h0 + 3);
        check("b2b_gap1", 32'(acc_cyc[a0 + 1] - acc_cyc[a0]),     5);
        check("b2b_gap2", 32'(acc_cyc[a0 + 2] - acc_cyc[a0 + 1]), 5);
        check("b2b_done_cnt", 32'(bus.done_cnt), 4);
        check("b2b_last_sum", 32'(bus.sum), 99);

        // Maximum operands: no truncation at any stage.
        run_op(15, 15, 255, 255);
        check("max_op1", 32'(bus.op1), 30);
        check("max_op2", 32'(bus.op2), 510);
        check("max_sum", 32'(bus.sum), 540);
        check("max_done_cnt", 32'(bus.done_cnt), 5);

        // Backpressure: result held, inputs ignored, no new accept.
        bus.out_ready = 1'b0;
        drive(5, 6, 7, 8);
        bus.in_valid = 1'b1;
        wait_accept(acc_cnt + 1);
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            next();
            n++;
        end
        a0 = acc_cnt;
        h0 = hand_cnt;
        for (int i = 0; i < 10; i++) begin
            drive($urandom_range(15, 0), $urandom_range(15, 0),
                  $urandom_range(255, 0), $urandom_range(255, 0));
            bus.in_valid = ~bus.in_valid;
            next();
            check("bp_out_valid", 32'(bus.out_valid), 1);
            check("bp_in_ready",  32'(bus.in_ready),  0);
            check("bp_sum",       32'(bus.sum),       26);
            check("bp_done_cnt",  32'(bus.done_cnt),  6 - 1);
        end
        check("bp_no_accept", 32'(acc_cnt), 32'(a0));
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_hand(h0 + 1);
        check("bp_done_cnt_after", 32'(bus.done_cnt), 6);
        check("bp_out_valid_after", 32'(bus.out_valid), 0);
        next();
        check("bp_single_handoff", 32'(bus.done_cnt), 6);

        // Reset while in S_OP2 discards the operation.
        drive(3, 4, 5, 6);
        bus.in_valid = 1'b1;
        wait_accept(acc_cnt + 1);
        bus.in_valid = 1'b0;
        next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        check("mid_rst_in_ready",  32'(bus.in_ready),  1);
        check("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check("mid_rst_busy",      32'(bus.busy),      0);
        check("mid_rst_op1",       32'(bus.op1),       0);
        check("mid_rst_op2",       32'(bus.op2),       0);
        check("mid_rst_sum",       32'(bus.sum),       0);
        check("mid_rst_done_cnt",  32'(bus.done_cnt),  0);
        run_op(1, 1, 1, 1);
        check("after_rst_sum",      32'(bus.sum),      4);
        check("after_rst_done_cnt", 32'(bus.done_cnt), 1);

        // Counter wrap after 256 handoffs from a fresh reset.
        rst = 1'b1;
        next();
        rst = 1'b0;
        check("wrap_start", 32'(bus.done_cnt), 0);
        for (int i = 1; i <= 256; i++) begin
            run_op($urandom_range(15, 0), $urandom_range(15, 0),
                   $urandom_range(255, 0), $urandom_range(255, 0));
            if (i == 255) check("wrap_255", 32'(bus.done_cnt), 255);
            if (i == 256) check("wrap_0",   32'(bus.done_cnt), 0);
        end
        check("wrap_model", 32'(bus.done_cnt), 32'(exp_done));

        next();
        check("sb_drained", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tree_add_seq.md
# tree_add_seq

Multi-cycle sequencer that computes the two-level operand tree op1 = a + b, op2 = c + d, sum = op1 + op2 using one shared adder instead of three parallel adders. It sits between an operand producer and a result consumer, with a valid/ready handshake on each side. The block trades throughput (one result per 5 cycles minimum) for area and reports completed operations on a wrapping counter.

## Interface
- A_W, default 4: width of a and b; must satisfy A_W <= C_W.
- C_W, default 8: width of c and d.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set a/b/c/d is valid.
- in_ready  out  1  block accepts operands this cycle.
- a, b  in  A_W  first-pair operands, unsigned.
- c, d  in  C_W  second-pair operands, unsigned.
- out_valid  out  1  op1/op2/sum hold a completed result.
- out_ready  in  1  consumer takes the result this cycle.
- op1  out  A_W+1  a + b.
- op2  out  C_W+1  c + d.
- sum  out  C_W+2  op1 + op2.
- busy  out  1  high in every state except IDLE.
- done_cnt  out  8  count of results handed off, wraps 255 -> 0.

## Operation
- States: IDLE, S_OP1, S_OP2, S_SUM, DONE.
- IDLE: in_ready = 1. On in_valid & in_ready, register a, b, c, d and go to S_OP1. Otherwise stay.
- S_OP1: the shared adder computes zero-extended a + b. Register the result into op1 and go to S_OP2.
- S_OP2: the shared adder computes c + d. Register the result into op2 and go to S_SUM.
- S_SUM: the shared adder computes zext(op1) + op2. Register the result into sum and go to DONE.
- DONE: out_valid = 1. op1, op2 and sum are held stable. On out_ready, increment done_cnt and go to IDLE. Otherwise stay in DONE indefinitely.
- Exactly one adder instance exists: C_W+2 bits wide, operands zero-extended, muxed by state. No carry is lost at any stage. The maximum result, 2*(2^A_W-1) + 2*(2^C_W-1), fits in C_W+2 bits.
- Operand inputs are sampled only on the accept edge. Changes on a/b/c/d outside IDLE are ignored.
- in_ready is 0 in all non-IDLE states, including DONE. No new accept happens in the same cycle as a result handoff.
- op1 and op2 may change while out_valid = 0. Consumers use them only when out_valid = 1.
- Reset: on any edge with rst = 1, go to IDLE and clear the following to 0: op1, op2, sum, out_valid, busy, done_cnt and the operand registers. This applies in any state; an in-flight operation is discarded and not counted. in_ready is 1 in the first cycle after reset deasserts.
- While rst = 1, in_valid and out_ready are ignored.

## Timing
- The accept edge is T0 (in_valid & in_ready both high).
- T1: op1 is valid. T2: op2 is valid. T3: sum is valid and out_valid rises.
- Latency from the accept edge to out_valid is 3 cycles.
- The handoff edge is the first edge with out_valid & out_ready. At that edge done_cnt increments, and out_valid and busy drop after it.
- in_ready rises in the cycle after handoff. Minimum spacing between accepts is 5 cycles when out_ready is held at 1.
- out_valid, once high, stays high until handoff or reset. sum and op1/op2 do not change while out_valid is high.
- busy = 1 from the cycle after accept through the handoff cycle inclusive.

## Test plan
- Basic result: a=0, b=3, c=1, d=255 with out_ready=1 -> out_valid exactly 3 cycles after accept with op1=3, op2=256, sum=259. done_cnt becomes 1. in_ready returns 1 cycle after handoff.
- Back-to-back stream with in_valid and out_ready held high:
  - (10, 13, 9, 10) -> 23/19/42
  - (15, 15, 109, 37) -> 30/146/176
  - (0, 9, 45, 45) -> 9/90/99
  - Accepts are exactly 5 cycles apart; done_cnt = 3.
- Maximum operands: a=b=15, c=d=255 -> op1=30, op2=510, sum=540, with no truncation.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid. Change a/b/c/d and toggle in_valid during that time -> out_valid stays 1, in_ready stays 0, sum stays constant, and no new accept occurs. Release out_ready -> single handoff and done_cnt increments once.
- Reset mid-operation: assert rst for 1 cycle in S_OP2 -> next cycle all outputs are 0 and in_ready=1. The next operation (1, 1, 1, 1) yields sum=4 and done_cnt=1.
- Counter wrap: complete 256 operations -> done_cnt reads 255 after handoff 255 and 0 after handoff 256.
